// File: rtl/ctrl_regq.sv
// ctrl_regq: SPI byte-bus decoder splitting a message-RAM window from a control
// register window, with a transmit length queue, sticky W1C status and an IRQ.
//
// state | meaning
// IDLE  | not busy; launches the queue head when the queue is non-empty
// RUN   | o_transmit high, waiting for the registered tx_done
// GAP   | one forced low cycle after a message, still busy
module ctrl_regq #(
    parameter int ADDR_W    = 10,
    parameter int RAM_DEPTH = 1000,
    parameter int LEN_W     = 10,
    parameter int QDEPTH    = 4,
    parameter int NGPIO     = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_wdata,
    input  logic              i_wr,
    input  logic              i_rd,
    output logic [7:0]        o_rdata,
    input  logic [7:0]        i_ram_data,
    output logic              o_ram_wr,
    output logic              o_ram_rd,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [7:0]        o_ram_data,
    input  logic              i_tx_done,
    input  logic [NGPIO-1:0]  i_gpios,
    output logic              o_transmit,
    output logic [LEN_W-1:0]  o_msg_length,
    output logic [1:0]        o_reg_speed,
    output logic              o_reg_cw,
    output logic              o_reg_use_fifo,
    output logic              o_reg_oqpsk,
    output logic              o_fifo_reset,
    output logic              o_irq
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int HI_W  = LEN_W - 8;

    localparam logic [ADDR_W-1:0] A_LEN_HI = ADDR_W'(RAM_DEPTH);
    localparam logic [ADDR_W-1:0] A_LEN_LO = ADDR_W'(RAM_DEPTH + 1);
    localparam logic [ADDR_W-1:0] A_CFG    = ADDR_W'(RAM_DEPTH + 2);
    localparam logic [ADDR_W-1:0] A_QCMD   = ADDR_W'(RAM_DEPTH + 3);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(RAM_DEPTH + 4);
    localparam logic [ADDR_W-1:0] A_IRQ_EN = ADDR_W'(RAM_DEPTH + 5);
    localparam logic [ADDR_W-1:0] A_GPIO   = ADDR_W'(RAM_DEPTH + 6);
    localparam logic [ADDR_W-1:0] A_ID2    = '1;
    localparam logic [ADDR_W-1:0] A_ID1    = A_ID2 - ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_ID0    = A_ID2 - ADDR_W'(2);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(QDEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [HI_W-1:0]   len_hi_q, len_hi_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [4:0]        cfg_q, cfg_d;
    logic [2:0]        irq_en_q, irq_en_d;
    logic [2:0]        sticky_q, sticky_d;
    logic              tx_done_q, tx_done_d;
    logic              fifo_reset_q, fifo_reset_d;
    logic              irq_q, irq_d;
    logic [LEN_W-1:0]  q_mem_q [QDEPTH];
    logic [LEN_W-1:0]  q_mem_d [QDEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              in_ram;
    logic              reg_wr;
    logic              wr_len_hi, wr_len_lo, wr_cfg, wr_qcmd, wr_status, wr_irq_en;
    logic              busy, full, empty;
    logic              push_req, flush_req, flush_ok, push_ok;
    logic              pop;
    logic              ovf_set, unr_set;
    logic [2:0]        w1c_mask;
    logic [LEN_W-1:0]  staged_len;
    logic [7:0]        reg_rdata;

    assign in_ram     = (i_addr < A_LEN_HI);
    assign reg_wr     = i_wr & ~in_ram;
    assign wr_len_hi  = reg_wr & (i_addr == A_LEN_HI);
    assign wr_len_lo  = reg_wr & (i_addr == A_LEN_LO);
    assign wr_cfg     = reg_wr & (i_addr == A_CFG);
    assign wr_qcmd    = reg_wr & (i_addr == A_QCMD);
    assign wr_status  = reg_wr & (i_addr == A_STATUS);
    assign wr_irq_en  = reg_wr & (i_addr == A_IRQ_EN);

    assign busy       = (state_q != ST_IDLE);
    assign full       = (cnt_q == CNT_FULL);
    assign empty      = (cnt_q == '0);
    assign staged_len = {len_hi_q, len_lo_q};

    assign push_req   = wr_qcmd & i_wdata[0];
    assign flush_req  = wr_qcmd & i_wdata[1];
    assign flush_ok   = flush_req & ~busy;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A flush taken this cycle must not launch the entries it removes.
                if (!empty && !flush_ok) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (tx_done_q) begin
                    pop     = 1'b1;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        q_mem_d  = q_mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        push_ok  = 1'b0;
        ovf_set  = 1'b0;
        unr_set  = flush_req & busy;
        if (flush_ok) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
            if (push_req) begin
                q_mem_d[0] = staged_len;
                wr_ptr_d   = PTR_W'(1);
                cnt_d      = CNT_W'(1);
            end
        end else begin
            // A pop in the same cycle frees the slot a push into a full queue needs.
            push_ok = push_req & (~full | pop);
            ovf_set = push_req & ~push_ok;
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_ok) begin
                q_mem_d[wr_ptr_q] = staged_len;
                wr_ptr_d          = wr_ptr_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop);
        end
    end

    always_comb begin
        len_hi_d     = len_hi_q;
        len_lo_d     = len_lo_q;
        cfg_d        = cfg_q;
        irq_en_d     = irq_en_q;
        if (wr_len_hi && !busy) len_hi_d = i_wdata[HI_W-1:0];
        if (wr_len_lo && !busy) len_lo_d = i_wdata;
        if (wr_cfg && !busy)    cfg_d    = i_wdata[4:0];
        if (wr_irq_en)          irq_en_d = i_wdata[2:0];
        w1c_mask     = wr_status ? i_wdata[2:0] : 3'b000;
        sticky_d     = (sticky_q & ~w1c_mask) | {unr_set, ovf_set, pop};
        tx_done_d    = i_tx_done & (state_q == ST_RUN);
        fifo_reset_d = wr_qcmd & i_wdata[2];
        irq_d        = |(sticky_q & irq_en_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            len_hi_q     <= '0;
            len_lo_q     <= '0;
            cfg_q        <= '0;
            irq_en_q     <= '0;
            sticky_q     <= '0;
            tx_done_q    <= 1'b0;
            fifo_reset_q <= 1'b0;
            irq_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            len_hi_q     <= len_hi_d;
            len_lo_q     <= len_lo_d;
            cfg_q        <= cfg_d;
            irq_en_q     <= irq_en_d;
            sticky_q     <= sticky_d;
            tx_done_q    <= tx_done_d;
            fifo_reset_q <= fifo_reset_d;
            irq_q        <= irq_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            q_mem_q      <= q_mem_d;
        end
    end

    always_comb begin
        reg_rdata = 8'h00;
        case (i_addr)
            A_LEN_HI: reg_rdata = 8'(len_hi_q);
            A_LEN_LO: reg_rdata = len_lo_q;
            A_CFG:    reg_rdata = {3'b000, cfg_q};
            A_QCMD:   reg_rdata = 8'(cnt_q);
            A_STATUS: reg_rdata = {busy, full, empty, 2'b00, sticky_q};
            A_IRQ_EN: reg_rdata = {5'b00000, irq_en_q};
            A_GPIO:   reg_rdata = 8'(i_gpios);
            A_ID0:    reg_rdata = 8'h96;
            A_ID1:    reg_rdata = 8'h02;
            A_ID2:    reg_rdata = 8'(QDEPTH);
            default:  reg_rdata = 8'h00;
        endcase
    end

    assign o_rdata        = in_ram ? i_ram_data : reg_rdata;
    assign o_ram_wr       = i_wr & in_ram;
    assign o_ram_rd       = i_rd & in_ram;
    assign o_ram_addr     = i_addr;
    assign o_ram_data     = i_wdata;
    assign o_transmit     = (state_q == ST_RUN);
    assign o_msg_length   = empty ? '0 : q_mem_q[rd_ptr_q];
    assign o_reg_speed    = cfg_q[1:0];
    assign o_reg_cw       = cfg_q[2];
    assign o_reg_use_fifo = cfg_q[3];
    assign o_reg_oqpsk    = cfg_q[4];
    assign o_fifo_reset   = fifo_reset_q;
    assign o_irq          = irq_q;

endmodule

// File: tb/tb_ctrl_regq.sv
// Bench for ctrl_regq: a queue-based reference model compared every cycle,
// plus directed register/queue scenarios with literal expectations.
module tb_ctrl_regq;

    localparam int ADDR_W    = 10;
    localparam int RAM_DEPTH = 1000;
    localparam int LEN_W     = 10;
    localparam int QDEPTH    = 4;
    localparam int NGPIO     = 4;

    logic              clk;
    logic              reset_n;
    logic [ADDR_W-1:0] i_addr;
    logic [7:0]        i_wdata;
    logic              i_wr;
    logic              i_rd;
    logic [7:0]        o_rdata;
    logic [7:0]        i_ram_data;
    logic              o_ram_wr;
    logic              o_ram_rd;
    logic [ADDR_W-1:0] o_ram_addr;
    logic [7:0]        o_ram_data;
    logic              i_tx_done;
    logic [NGPIO-1:0]  i_gpios;
    logic              o_transmit;
    logic [LEN_W-1:0]  o_msg_length;
    logic [1:0]        o_reg_speed;
    logic              o_reg_cw;
    logic              o_reg_use_fifo;
    logic              o_reg_oqpsk;
    logic              o_fifo_reset;
    logic              o_irq;

    int checks   = 0;
    int failures = 0;

    ctrl_regq #(
        .ADDR_W(ADDR_W), .RAM_DEPTH(RAM_DEPTH), .LEN_W(LEN_W),
        .QDEPTH(QDEPTH), .NGPIO(NGPIO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_wr(i_wr), .i_rd(i_rd), .o_rdata(o_rdata), .i_ram_data(i_ram_data),
        .o_ram_wr(o_ram_wr), .o_ram_rd(o_ram_rd), .o_ram_addr(o_ram_addr),
        .o_ram_data(o_ram_data), .i_tx_done(i_tx_done), .i_gpios(i_gpios),
        .o_transmit(o_transmit), .o_msg_length(o_msg_length),
        .o_reg_speed(o_reg_speed), .o_reg_cw(o_reg_cw),
        .o_reg_use_fifo(o_reg_use_fifo), .o_reg_oqpsk(o_reg_oqpsk),
        .o_fifo_reset(o_fifo_reset), .o_irq(o_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    // Reference model: pending lengths as a plain queue, transmitter as
    // "sending" / "cooling down" flags, sticky bits as a 3-bit vector.
    int       mq[$];
    bit       m_tx, m_gap, m_dn, m_frst, m_irq;
    bit [2:0] m_st, m_en;
    bit [4:0] m_cfg;
    int       m_hi, m_lo;

    function automatic logic [7:0] m_read(input int a);
        logic [7:0] r;
        r = 8'h00;
        if (a < RAM_DEPTH) r = i_ram_data;
        else if (a == RAM_DEPTH)     r = 8'(m_hi);
        else if (a == RAM_DEPTH + 1) r = 8'(m_lo);
        else if (a == RAM_DEPTH + 2) r = {3'b000, m_cfg};
        else if (a == RAM_DEPTH + 3) r = 8'(mq.size());
        else if (a == RAM_DEPTH + 4) r = {(m_tx || m_gap), (mq.size() == QDEPTH), (mq.size() == 0), 2'b00, m_st};
        else if (a == RAM_DEPTH + 5) r = {5'b00000, m_en};
        else if (a == RAM_DEPTH + 6) r = 8'(i_gpios);
        else if (a == (1 << ADDR_W) - 3) r = 8'h96;
        else if (a == (1 << ADDR_W) - 2) r = 8'h02;
        else if (a == (1 << ADDR_W) - 1) r = 8'(QDEPTH);
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_tx = 0; m_gap = 0; m_dn = 0; m_frst = 0; m_irq = 0;
        m_st = 0; m_en = 0; m_cfg = 0; m_hi = 0; m_lo = 0;
    endtask

    task automatic model_step();
        int a, n_before, staged;
        bit w, busy, finish, flush, push, fl_ok, launch, new_irq;
        bit [2:0] st;
        a        = int'(i_addr);
        w        = i_wr && (a >= RAM_DEPTH);
        busy     = m_tx || m_gap;
        finish   = m_tx && m_dn;
        flush    = w && (a == RAM_DEPTH + 3) && i_wdata[1];
        push     = w && (a == RAM_DEPTH + 3) && i_wdata[0];
        fl_ok    = flush && !busy;
        launch   = !busy && (mq.size() > 0) && !fl_ok;
        n_before = mq.size();
        new_irq  = |(m_st & m_en);
        staged   = m_hi * 256 + m_lo;
        st       = m_st;
        if (w && a == RAM_DEPTH + 4) st = st & ~i_wdata[2:0];
        if (flush && busy) st[2] = 1'b1;
        if (fl_ok) mq.delete();
        if (finish) begin
            void'(mq.pop_front());
            st[0] = 1'b1;
        end
        if (push) begin
            if (fl_ok || n_before < QDEPTH || finish) mq.push_back(staged);
            else st[1] = 1'b1;
        end
        if (w && !busy && a == RAM_DEPTH)     m_hi = int'(i_wdata) % (1 << (LEN_W - 8));
        if (w && !busy && a == RAM_DEPTH + 1) m_lo = int'(i_wdata);
        if (w && !busy && a == RAM_DEPTH + 2) m_cfg = i_wdata[4:0];
        if (w && a == RAM_DEPTH + 5) m_en = i_wdata[2:0];
        m_frst = w && (a == RAM_DEPTH + 3) && i_wdata[2];
        m_dn   = i_tx_done && m_tx;
        if (finish) m_tx = 1'b0;
        else if (launch) m_tx = 1'b1;
        m_gap  = finish;
        m_irq  = new_irq;
        m_st   = st;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("transmit", o_transmit, m_tx);
            chk("msg_length", o_msg_length, (mq.size() > 0) ? mq[0] : 0);
            chk("irq", o_irq, m_irq);
            chk("fifo_reset", o_fifo_reset, m_frst);
            chk("ram_wr", o_ram_wr, i_wr && (int'(i_addr) < RAM_DEPTH));
            chk("ram_rd", o_ram_rd, i_rd && (int'(i_addr) < RAM_DEPTH));
            chk("rdata", o_rdata, m_read(int'(i_addr)));
            chk("cfg_out", {o_reg_oqpsk, o_reg_use_fifo, o_reg_cw, o_reg_speed}, m_cfg);
            chk("ram_bus", {o_ram_addr, o_ram_data}, {i_addr, i_wdata});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        i_addr  = ADDR_W'(a);
        i_wdata = 8'(d);
        i_wr    = 1'b1;
        step();
        i_wr    = 1'b0;
    endtask

    task automatic rd_check(input int a, input int want, input string name);
        i_addr = ADDR_W'(a);
        i_rd   = 1'b1;
        #2;
        chk(name, o_rdata, want);
        step();
        i_rd   = 1'b0;
    endtask

    task automatic wait_high(output int lows);
        lows = 0;
        for (int c = 0; c < 50 && o_transmit !== 1'b1; c++) begin
            lows++;
            step();
        end
        if (o_transmit !== 1'b1) chk("wait_transmit_timeout", o_transmit, 1);
    endtask

    task automatic pulse_done();
        i_tx_done = 1'b1;
        step();
        i_tx_done = 1'b0;
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int lows;
        int exp_len [3];
        exp_len[0] = 'h110;
        exp_len[1] = 'h120;
        exp_len[2] = 'h120;

        i_addr = '0; i_wdata = '0; i_wr = 0; i_rd = 0;
        i_ram_data = 8'h00; i_tx_done = 0; i_gpios = 4'hA;
        reset_n = 1'b0;
        #12;
        chk("rst_transmit", o_transmit, 0);
        chk("rst_msg_length", o_msg_length, 0);
        chk("rst_irq", o_irq, 0);
        chk("rst_fifo_reset", o_fifo_reset, 0);
        chk("rst_rdata_addr0", o_rdata, 0);
        chk("rst_ram_wr", o_ram_wr, 0);
        reset_n = 1'b1;
        step();
        i_ram_data = 8'h5A;

        rd_check(1021, 'h96, "id0");
        rd_check(1022, 'h02, "id1");
        rd_check(1023, 'h04, "id2");
        rd_check(1004, 'h20, "status_reset");
        rd_check(1006, 'h0A, "gpio");
        rd_check(1010, 'h00, "unmapped");
        wr(1002, 'h05);
        chk("cfg_speed", o_reg_speed, 1);
        chk("cfg_cw", o_reg_cw, 1);

        // single message of length 300
        wr(1000, 'h01);
        wr(1001, 'h2C);
        wr(1003, 'h01);
        chk("len_after_push", o_msg_length, 300);
        chk("tx_before_launch", o_transmit, 0);
        step();
        chk("tx_launch", o_transmit, 1);
        pulse_done();
        chk("tx_hold_after_done", o_transmit, 1);
        step();
        chk("tx_drop", o_transmit, 0);
        rd_check(1004, 'hA1, "status_gap");
        rd_check(1004, 'h21, "status_done");
        wr(1004, 'h01);

        // three back-to-back messages
        wr(1001, 'h10);
        wr(1003, 'h01);
        wr(1001, 'h20);
        wr(1003, 'h01);
        wr(1000, 'h00);
        wr(1003, 'h01);
        rd_check(1000, 'h01, "len_hi_locked");
        rd_check(1003, 3, "count3");
        for (int i = 0; i < 3; i++) begin
            wait_high(lows);
            chk("queued_len", o_msg_length, exp_len[i]);
            if (i > 0) chk("gap_low_cycles", lows, 2);
            pulse_done();
            step();
        end
        step();
        rd_check(1004, 'h21, "status_drained");

        // overflow
        wr(1004, 'h07);
        for (int i = 0; i < 5; i++) wr(1003, 'h01);
        rd_check(1003, 4, "count_full");
        rd_check(1004, 'hC2, "status_full_ovf");
        wr(1004, 'h02);
        rd_check(1004, 'hC0, "ovf_cleared");

        // busy: config locked, flush refused
        wr(1002, 'h1F);
        rd_check(1002, 'h05, "cfg_locked");
        wr(1003, 'h02);
        rd_check(1003, 4, "flush_ignored");
        rd_check(1004, 'hC4, "status_underrun");
        wr(1005, 'h04);
        chk("irq_lag", o_irq, 0);
        step();
        chk("irq_set", o_irq, 1);
        for (int i = 0; i < 4; i++) begin
            wait_high(lows);
            pulse_done();
            step();
        end
        step();
        step();
        wr(1004, 'h07);
        wr(1005, 'h00);
        wr(1003, 'h02);
        rd_check(1004, 'h20, "flush_idle_ok");

        // RAM window decode
        i_addr = ADDR_W'(999); i_wdata = 8'hAB; i_wr = 1'b1;
        #2;
        chk("ram_wr_999", o_ram_wr, 1);
        chk("ram_data", o_ram_data, 'hAB);
        step();
        i_addr = ADDR_W'(1000); i_wdata = 8'h00;
        #2;
        chk("ram_wr_1000", o_ram_wr, 0);
        step();
        i_wr = 1'b0;
        rd_check(5, 'h5A, "ram_rdata");

        // fifo reset pulse
        wr(1003, 'h04);
        chk("fifo_reset_pulse", o_fifo_reset, 1);
        step();
        chk("fifo_reset_end", o_fifo_reset, 0);

        // asynchronous reset while running
        wr(1001, 'h33);
        wr(1003, 'h01);
        step();
        chk("tx_before_reset", o_transmit, 1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_transmit", o_transmit, 0);
        chk("async_rst_msg_length", o_msg_length, 0);
        chk("async_rst_irq", o_irq, 0);
        reset_n = 1'b1;
        step();
        rd_check(1003, 0, "count_after_reset");
        rd_check(1004, 'h20, "status_after_reset");
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
